fpu_add_wb: RTL and testbench

Writeback stage directly downstream of the single-precision FP adder. Captures each adder result (`fp_result`, `overflow`, `underflow`) with a destination tag into a small FIFO. Presents results to the register-file writer over a valid/ready handshake. Maintains the sticky IEEE exception-flag register (fflags) plus a committed-operation counter.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_wb_fifo.sv | 61 ++++++
 rtl/fpu_add_wb.sv | 112 +++++++++++
 tb/tb_fpu_add_wb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP adder writeback stage: flag bit positions,
// the canonical quiet NaN and the FIFO entry layout.
package fpu_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Circular-buffer FIFO of wb_entry_t. DEPTH must be a power of two so the
// pointers wrap naturally. Push while full and pop while empty are ignored.
// Storage is cleared on reset so the head never shows X.
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wdata,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fpu_add_wb.sv
// Writeback stage after the single-precision FP adder: derives IEEE flags
// for each result, queues {result, rd, flags}, hands entries to the
// register-file writer, accumulates sticky fflags and counts commits.
//
// Build option: define FPU_WB_CANON_NAN_EN to replace any NaN result with
// the canonical quiet NaN at push time and raise NV for signalling NaNs.
// Without it results pass through bit-exact and NV stays 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on registered occupancy (never on out_ready), so a
// full FIFO refuses a push even when the head is popped the same cycle.
// Once out_valid is high the head entry holds steady until it is popped.
module fpu_add_wb
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] op_count
);

  wb_entry_t                in_entry;
  wb_entry_t                head;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     push;
  logic                     pop;
  logic [31:0]              push_result;
  logic                     push_nv;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef FPU_WB_CANON_NAN_EN
  logic is_nan;
  logic is_snan;
  assign is_nan      = (&in_result[30:23]) && (|in_result[22:0]);
  assign is_snan     = is_nan && !in_result[22];
  assign push_result = is_nan ? CANON_NAN : in_result;
  assign push_nv     = is_snan;
`else
  assign push_result = in_result;
  assign push_nv     = 1'b0;
`endif

  // Build the entry stored at push: result, tag and derived flags.
  always_comb begin
    in_entry                 = '0;
    in_entry.result          = push_result;
    in_entry.rd              = in_rd;
    in_entry.flags[FLAG_NV]  = push_nv;
    in_entry.flags[FLAG_DZ]  = 1'b0;
    in_entry.flags[FLAG_OF]  = in_overflow;
    in_entry.flags[FLAG_UF]  = in_underflow;
    in_entry.flags[FLAG_NX]  = in_overflow | in_underflow;
  end

  fpu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_flags  = head.flags;

  // Sticky flags: clear first, then OR in the popped entry so its flags survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else begin
      fflags <= (fflags_clr ? 5'b0 : fflags) | (pop ? head.flags : 5'b0);
    end
  end

  // Saturating count of committed (popped) results.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (pop && (op_count != '1)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_add_wb.sv
// Directed testbench for fpu_add_wb. Counter width is reduced to 4 bits so
// saturation can be reached quickly. Inputs change 1 time unit after each
// rising edge; outputs are sampled at that same point.
module tb_fpu_add_wb;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_overflow;
  logic             in_underflow;
  logic [4:0]       in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_rd;
  logic [4:0]       out_flags;
  logic [4:0]       fflags;
  logic             fflags_clr;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_errors = 0;

  // expected {result, rd} of queued entries, in push order
  logic [36:0] exp_q[$];

  fpu_add_wb #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_flags    (out_flags),
    .fflags       (fflags),
    .fflags_clr   (fflags_clr),
    .op_count     (op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    in_valid     = 1'b0;
    in_result    = '0;
    in_overflow  = 1'b0;
    in_underflow = 1'b0;
    in_rd        = '0;
  endtask

  task automatic push_one(input logic [31:0] res, input logic [4:0] rd,
                          input logic ovf, input logic unf);
    in_valid     = 1'b1;
    in_result    = res;
    in_rd        = rd;
    in_overflow  = ovf;
    in_underflow = unf;
    step();
    drive_idle();
  endtask

  // pop everything in exp_q, checking order, then check empty
  task automatic drain(input string tag);
    logic [36:0] e;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_result"}, 64'(out_result), 64'(e[36:5]));
      check({tag, "_rd"}, 64'(out_rd), 64'(e[4:0]));
      step();
    end
    out_ready = 1'b0;
    check({tag, "_empty"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] fill_vals [4];
  logic [31:0] nan_exp;
  logic [4:0]  nv_exp;

  initial begin
    fill_vals[0] = 32'h3F800000;
    fill_vals[1] = 32'h40000000;
    fill_vals[2] = 32'hC0A00000;
    fill_vals[3] = 32'h41200000;

    rst = 1'b1; out_ready = 1'b0; fflags_clr = 1'b0;
    drive_idle();
    step();
    step();

    // reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    rst = 1'b0;

    // single push with out_ready held high: visible the next cycle, popped the one after
    out_ready = 1'b1;
    push_one(32'h40400000, 5'd3, 1'b0, 1'b0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_result", 64'(out_result), 64'h40400000);
    check("single_rd", 64'(out_rd), 64'd3);
    check("single_flags", 64'(out_flags), 64'd0);
    check("single_cnt_before", 64'(op_count), 64'd0);
    step();
    check("single_cnt_after", 64'(op_count), 64'd1);
    check("single_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // fill to full, 5th push refused, drain in order
    for (int i = 0; i < 4; i++) begin
      push_one(fill_vals[i], 5'(i + 1), 1'b0, 1'b0);
      exp_q.push_back({fill_vals[i], 5'(i + 1)});
    end
    check("fill_full", 64'(in_ready), 64'd0);
    push_one(32'hDEADBEEF, 5'd31, 1'b0, 1'b0);
    check("fill_still_full", 64'(in_ready), 64'd0);
    drain("fill_drain");
    check("fill_op_count", 64'(op_count), 64'd5);

    // full with simultaneous push and pop: only the pop happens
    for (int i = 0; i < 4; i++) begin
      push_one(fill_vals[i], 5'(i + 10), 1'b0, 1'b0);
    end
    in_valid = 1'b1; in_result = 32'h12345678; in_rd = 5'd9; out_ready = 1'b1;
    step();
    drive_idle(); out_ready = 1'b0;
    check("fullpop_in_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i < 4; i++) exp_q.push_back({fill_vals[i], 5'(i + 10)});
    drain("fullpop_drain");
    check("fullpop_op_count", 64'(op_count), 64'd9);

    // flags: overflow entry then a clear coinciding with an underflow pop
    push_one(32'h7F800000, 5'd1, 1'b1, 1'b0);
    check("of_entry_flags", 64'(out_flags), 64'b00101);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("of_fflags", 64'(fflags), 64'b00101);
    push_one(32'h00000001, 5'd2, 1'b0, 1'b1);
    check("uf_entry_flags", 64'(out_flags), 64'b00011);
    check("uf_fflags_sticky", 64'(fflags), 64'b00101);
    out_ready = 1'b1; fflags_clr = 1'b1; step(); out_ready = 1'b0;
    check("clr_pop_fflags", 64'(fflags), 64'b00011);
    step();
    fflags_clr = 1'b0;
    check("clr_only_fflags", 64'(fflags), 64'b00000);

    // NaN handling
`ifdef FPU_WB_CANON_NAN_EN
    nan_exp = 32'h7FC00000; nv_exp = 5'b10000;
`else
    nan_exp = 32'h7F800001; nv_exp = 5'b00000;
`endif
    push_one(32'h7F800001, 5'd4, 1'b0, 1'b0);
    check("snan_result", 64'(out_result), 64'(nan_exp));
    check("snan_flags", 64'(out_flags), 64'(nv_exp));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("snan_fflags", 64'(fflags), 64'(nv_exp));
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
`ifdef FPU_WB_CANON_NAN_EN
    nan_exp = 32'h7FC00000;
`else
    nan_exp = 32'hFFC00123;
`endif
    push_one(32'hFFC00123, 5'd5, 1'b0, 1'b0);
    check("qnan_result", 64'(out_result), 64'(nan_exp));
    check("qnan_flags", 64'(out_flags), 64'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // sustained throughput with out_ready high; counter saturates at 4'hF
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_result = 32'h50000000 + 32'(i); in_rd = 5'(i);
      step();
      check("thru_ready", 64'(in_ready), 64'd1);
      check("thru_result", 64'(out_result), 64'h50000000 + 64'(i));
    end
    drive_idle();
    step();
    out_ready = 1'b0;
    check("sat_op_count", 64'(op_count), 64'hF);
    check("thru_empty", 64'(out_valid), 64'd0);

    // reset mid-stream with a push in the reset cycle
    push_one(32'h7F7FFFFF, 5'd6, 1'b1, 1'b0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("pre_rst_fflags", 64'(fflags), 64'b00101);
    for (int i = 0; i < 3; i++) push_one(fill_vals[i], 5'(i + 20), 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_result = 32'hCAFEF00D; in_rd = 5'd7;
    step();
    rst = 1'b0; drive_idle();
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_result", 64'(out_result), 64'd0);
    check("mrst_fflags", 64'(fflags), 64'd0);
    check("mrst_op_count", 64'(op_count), 64'd0);
    push_one(32'h3F000000, 5'd8, 1'b0, 1'b0);
    exp_q.push_back({32'h3F000000, 5'd8});
    drain("post_rst");
    check("post_rst_op_count", 64'(op_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
